// File: rtl/serv_bus_arbiter.sv
// serv_bus_arbiter
//   Shares one Wishbone master port between the SERV instruction bus (ibus)
//   and data bus (dbus). Requests are captured into registers in IDLE. When
//   both ports request at once, the grant alternates between them. The
//   Wishbone response is returned to the owning port one cycle later. A
//   watchdog aborts a bus cycle that is never acknowledged. The abort
//   completes the cycle with zero read data and a one-cycle error pulse.
//
// Parameters
//   TIMEOUT_W     width of the watchdog counter
//   TIMEOUT       GRANT cycles without ack before abort; 0 disables the watchdog
//
// Ports
//   i_clk, i_rst_n                        clock, async active-low reset
//   i_ibus_adr/cyc, o_ibus_rdt/ack        instruction fetch port
//   i_dbus_adr/dat/sel/we/cyc             data load/store request
//   o_dbus_rdt/ack                        data response
//   o_wb_adr/dat/sel/we/cyc               shared Wishbone request (registered)
//   i_wb_rdt/ack                          shared Wishbone response
//   o_timeout_err                         one-cycle pulse on watchdog abort
module serv_bus_arbiter #(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_timeout_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  localparam bit                   WD_EN    = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : TIMEOUT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IBUS = 1'b0,
    OWN_DBUS = 1'b1
  } owner_t;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic          we;
  } wb_req_t;

  state_t               state_q, state_d;
  owner_t               owner_q, owner_d;
  owner_t               last_q, last_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  wb_req_t              wb_q, wb_d;
  logic                 wb_cyc_d;
  logic [DW-1:0]        ibus_rdt_d, dbus_rdt_d;
  logic                 ibus_ack_d, dbus_ack_d, err_d;
  logic                 grant_dbus;

  assign o_wb_adr = wb_q.adr;
  assign o_wb_dat = wb_q.dat;
  assign o_wb_sel = wb_q.sel;
  assign o_wb_we  = wb_q.we;

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      owner_q       <= OWN_IBUS;
      last_q        <= OWN_IBUS;
      cnt_q         <= '0;
      wb_q          <= '0;
      o_wb_cyc      <= 1'b0;
      o_ibus_rdt    <= '0;
      o_dbus_rdt    <= '0;
      o_ibus_ack    <= 1'b0;
      o_dbus_ack    <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      wb_q          <= wb_d;
      o_wb_cyc      <= wb_cyc_d;
      o_ibus_rdt    <= ibus_rdt_d;
      o_dbus_rdt    <= dbus_rdt_d;
      o_ibus_ack    <= ibus_ack_d;
      o_dbus_ack    <= dbus_ack_d;
      o_timeout_err <= err_d;
    end
  end

  // Next-state, grant selection, watchdog and response routing
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    wb_d       = wb_q;
    wb_cyc_d   = o_wb_cyc;
    ibus_rdt_d = o_ibus_rdt;
    dbus_rdt_d = o_dbus_rdt;
    ibus_ack_d = 1'b0;
    dbus_ack_d = 1'b0;
    err_d      = 1'b0;
    // dbus wins when alone, or on contention when ibus had the previous grant
    grant_dbus = i_dbus_cyc && (!i_ibus_cyc || (last_q == OWN_IBUS));

    unique case (state_q)
      S_IDLE: begin
        if (i_ibus_cyc || i_dbus_cyc) begin
          if (grant_dbus) begin
            owner_d = OWN_DBUS;
            wb_d    = '{adr: i_dbus_adr, dat: i_dbus_dat, sel: i_dbus_sel, we: i_dbus_we};
          end else begin
            owner_d = OWN_IBUS;
            wb_d    = '{adr: i_ibus_adr, dat: '0, sel: {SW{1'b1}}, we: 1'b0};
          end
          last_d   = owner_d;
          cnt_d    = '0;
          wb_cyc_d = 1'b1;
          state_d  = S_GRANT;
        end
      end

      S_GRANT: begin
        if (i_wb_ack) begin
          // An ack arriving on the watchdog's last cycle is a normal completion
          wb_cyc_d = 1'b0;
          state_d  = S_RESP;
          if (owner_q == OWN_DBUS) begin
            dbus_ack_d = 1'b1;
            dbus_rdt_d = wb_q.we ? '0 : i_wb_rdt;
          end else begin
            ibus_ack_d = 1'b1;
            ibus_rdt_d = i_wb_rdt;
          end
        end else if (WD_EN && (cnt_q == CNT_LAST)) begin
          wb_cyc_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_RESP;
          if (owner_q == OWN_DBUS) begin
            dbus_ack_d = 1'b1;
            dbus_rdt_d = '0;
          end else begin
            ibus_ack_d = 1'b1;
            ibus_rdt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end

      S_RESP: begin
        // Requester still holds cyc this cycle; treat it as stale
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        wb_cyc_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
module tb_serv_bus_arbiter;

  localparam int unsigned TO = 8;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        o_timeout_err;

  int total = 0;
  int bad   = 0;

  // Transaction-level reference state
  bit          m_last;   // 0 = ibus had last grant, 1 = dbus
  logic [31:0] m_irdt;
  logic [31:0] m_drdt;
  int          m_owners[$];

  serv_bus_arbiter #(.TIMEOUT_W(8), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
    .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
    .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc),
    .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack),
    .o_timeout_err(o_timeout_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One bus transaction starting from IDLE with the current requests.
  // delay = GRANT cycles before the slave acks (>= TO means never).
  task automatic run_txn(input string nm, input int delay, input logic [31:0] rdt, input bit drop);
    bit          own_d;
    bit          to;
    bit          done;
    int          n;
    logic [31:0] e_adr, e_dat, e_irdt, e_drdt;
    logic [3:0]  e_sel;
    logic        e_we;
    own_d = i_dbus_cyc && (!i_ibus_cyc || !m_last);
    if (own_d) begin
      e_adr = i_dbus_adr; e_dat = i_dbus_dat; e_sel = i_dbus_sel; e_we = i_dbus_we;
    end else begin
      e_adr = i_ibus_adr; e_dat = 32'h0; e_sel = 4'hf; e_we = 1'b0;
    end
    m_owners.push_back(int'(own_d));
    @(negedge i_clk);
    n = 1; done = 1'b0; to = 1'b0;
    while (!done) begin
      total++;
      if (o_wb_cyc !== 1'b1 || o_wb_adr !== e_adr || o_wb_dat !== e_dat ||
          o_wb_sel !== e_sel || o_wb_we !== e_we) begin
        bad++;
        $display("FAIL %s grant cyc%0d: cyc=%b adr=%h dat=%h sel=%h we=%b, want cyc=1 adr=%h dat=%h sel=%h we=%b",
                 nm, n, o_wb_cyc, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, e_adr, e_dat, e_sel, e_we);
      end
      i_wb_ack = (n - 1 == delay);
      i_wb_rdt = i_wb_ack ? rdt : $urandom;
      if (drop && n == 2) begin
        if (own_d) i_dbus_cyc = 1'b0; else i_ibus_cyc = 1'b0;
      end
      to   = !i_wb_ack;
      done = i_wb_ack || (n == int'(TO));
      @(negedge i_clk);
      n++;
    end
    i_wb_ack = 1'b0;
    m_last = own_d;
    e_irdt = m_irdt;
    e_drdt = m_drdt;
    if (own_d) e_drdt = (to || e_we) ? 32'h0 : rdt;
    else       e_irdt = to ? 32'h0 : rdt;
    m_irdt = e_irdt;
    m_drdt = e_drdt;
    total++;
    if (o_wb_cyc !== 1'b0 || o_ibus_ack !== !own_d || o_dbus_ack !== own_d ||
        o_timeout_err !== to || o_ibus_rdt !== e_irdt || o_dbus_rdt !== e_drdt) begin
      bad++;
      $display("FAIL %s resp: cyc=%b iack=%b dack=%b err=%b irdt=%h drdt=%h, want cyc=0 iack=%b dack=%b err=%b irdt=%h drdt=%h",
               nm, o_wb_cyc, o_ibus_ack, o_dbus_ack, o_timeout_err, o_ibus_rdt, o_dbus_rdt,
               !own_d, own_d, to, e_irdt, e_drdt);
    end
    // Requester releases; a stray ack in RESP must be ignored
    if (own_d) i_dbus_cyc = 1'b0; else i_ibus_cyc = 1'b0;
    i_wb_ack = 1'($urandom_range(0, 1));
    i_wb_rdt = $urandom;
    @(negedge i_clk);
    i_wb_ack = 1'b0;
    total++;
    if (o_wb_cyc !== 1'b0 || o_ibus_ack !== 1'b0 || o_dbus_ack !== 1'b0 || o_timeout_err !== 1'b0 ||
        o_ibus_rdt !== m_irdt || o_dbus_rdt !== m_drdt) begin
      bad++;
      $display("FAIL %s idle: cyc=%b iack=%b dack=%b err=%b irdt=%h drdt=%h, want 0 0 0 0 %h %h",
               nm, o_wb_cyc, o_ibus_ack, o_dbus_ack, o_timeout_err, o_ibus_rdt, o_dbus_rdt, m_irdt, m_drdt);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_ibus_adr = 32'h0; i_ibus_cyc = 1'b0;
    i_dbus_adr = 32'h0; i_dbus_dat = 32'h0; i_dbus_sel = 4'h0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
    i_wb_rdt = 32'h0; i_wb_ack = 1'b0;
    m_last = 1'b0; m_irdt = 32'h0; m_drdt = 32'h0;
    repeat (2) @(negedge i_clk);
    total++;
    if (o_wb_cyc !== 1'b0 || o_ibus_ack !== 1'b0 || o_dbus_ack !== 1'b0 || o_timeout_err !== 1'b0 ||
        o_wb_adr !== 32'h0 || o_wb_dat !== 32'h0 || o_wb_sel !== 4'h0 || o_wb_we !== 1'b0 ||
        o_ibus_rdt !== 32'h0 || o_dbus_rdt !== 32'h0) begin
      bad++;
      $display("FAIL reset_values: cyc=%b iack=%b dack=%b err=%b adr=%h dat=%h sel=%h we=%b, want all 0",
               o_wb_cyc, o_ibus_ack, o_dbus_ack, o_timeout_err, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    // Start a fetch and assert reset while the slave stalls
    i_ibus_adr = 32'h40; i_ibus_cyc = 1'b1;
    repeat (3) @(negedge i_clk);
    total++;
    if (o_wb_cyc !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_grant: cyc=%b want 1", o_wb_cyc);
    end
    i_rst_n = 1'b0;
    #1;
    total++;
    if (o_wb_cyc !== 1'b0 || o_ibus_ack !== 1'b0 || o_dbus_ack !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: cyc=%b iack=%b dack=%b, want 0 0 0", o_wb_cyc, o_ibus_ack, o_dbus_ack);
    end
    i_ibus_cyc = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    m_last = 1'b0;
    @(negedge i_clk);
    // First contention after reset goes to dbus
    i_ibus_adr = 32'h80; i_ibus_cyc = 1'b1;
    i_dbus_adr = 32'h3000; i_dbus_dat = 32'h1234_5678; i_dbus_sel = 4'hc; i_dbus_we = 1'b0; i_dbus_cyc = 1'b1;
    run_txn("reset_contend_dbus", 1, 32'haaaa_5555, 1'b0);
    total++;
    if (m_owners[m_owners.size() - 1] != 1 || o_dbus_rdt !== 32'haaaa_5555) begin
      bad++;
      $display("FAIL reset_first_owner: drdt=%h want aaaa5555", o_dbus_rdt);
    end
    // Drain the pending ibus request
    run_txn("reset_drain_ibus", 0, 32'h0000_0001, 1'b0);
  endtask

  task automatic test_fetch();
    i_ibus_adr = 32'h100; i_ibus_cyc = 1'b1;
    run_txn("fetch", 2, 32'h0000_0013, 1'b0);
    total++;
    if (o_ibus_rdt !== 32'h0000_0013) begin
      bad++;
      $display("FAIL fetch_rdt: irdt=%h want 00000013", o_ibus_rdt);
    end
  endtask

  task automatic test_contention();
    bit exp_d;
    i_ibus_adr = 32'h200; i_ibus_cyc = 1'b1;
    i_dbus_adr = 32'h4000; i_dbus_dat = 32'h0; i_dbus_sel = 4'hf; i_dbus_we = 1'b0; i_dbus_cyc = 1'b1;
    exp_d = !m_last;
    for (int k = 0; k < 4; k++) begin
      run_txn("contend", k, $urandom, 1'b0);
      total++;
      if (m_owners[m_owners.size() - 1] != int'(exp_d)) begin
        bad++;
        $display("FAIL contend_alternate: round %0d owner=%0d want %0d", k, m_owners[m_owners.size() - 1], exp_d);
      end
      exp_d = !exp_d;
      // Winner re-requests immediately, loser is still waiting
      i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1;
    end
    // Finish the outstanding pair
    run_txn("contend_drain0", 0, $urandom, 1'b0);
    run_txn("contend_drain1", 0, $urandom, 1'b0);
  endtask

  task automatic test_store();
    i_dbus_adr = 32'h2000; i_dbus_dat = 32'hdead_beef; i_dbus_sel = 4'h3; i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
    run_txn("store", 1, 32'hffff_ffff, 1'b0);
    total++;
    if (o_dbus_rdt !== 32'h0) begin
      bad++;
      $display("FAIL store_rdt: drdt=%h want 00000000", o_dbus_rdt);
    end
  endtask

  task automatic test_watchdog();
    i_dbus_adr = 32'h5000; i_dbus_dat = 32'h0; i_dbus_sel = 4'hf; i_dbus_we = 1'b0; i_dbus_cyc = 1'b1;
    run_txn("wd_load_before", 0, 32'h7777_7777, 1'b0);
    i_dbus_cyc = 1'b1;
    run_txn("wd_abort", int'(TO), 32'h0, 1'b0);
    total++;
    if (o_dbus_rdt !== 32'h0) begin
      bad++;
      $display("FAIL wd_abort_rdt: drdt=%h want 00000000", o_dbus_rdt);
    end
    i_dbus_cyc = 1'b1;
    run_txn("wd_ack_last", int'(TO) - 1, 32'h8888_0001, 1'b0);
    i_ibus_adr = 32'h600; i_ibus_cyc = 1'b1;
    run_txn("wd_abort_ibus", int'(TO), 32'h0, 1'b0);
  endtask

  task automatic test_stray_ack();
    for (int k = 0; k < 3; k++) begin
      i_wb_ack = 1'b1;
      i_wb_rdt = $urandom;
      @(negedge i_clk);
      total++;
      if (o_wb_cyc !== 1'b0 || o_ibus_ack !== 1'b0 || o_dbus_ack !== 1'b0 || o_timeout_err !== 1'b0 ||
          o_ibus_rdt !== m_irdt || o_dbus_rdt !== m_drdt) begin
        bad++;
        $display("FAIL stray_idle_ack: cyc=%b iack=%b dack=%b err=%b irdt=%h drdt=%h, want 0 0 0 0 %h %h",
                 o_wb_cyc, o_ibus_ack, o_dbus_ack, o_timeout_err, o_ibus_rdt, o_dbus_rdt, m_irdt, m_drdt);
      end
    end
    i_wb_ack = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_random();
    int d;
    for (int it = 0; it < 60; it++) begin
      if (!i_ibus_cyc && $urandom_range(0, 1) == 1) begin
        i_ibus_adr = $urandom; i_ibus_cyc = 1'b1;
      end
      if (!i_dbus_cyc && $urandom_range(0, 1) == 1) begin
        i_dbus_adr = $urandom; i_dbus_dat = $urandom;
        i_dbus_sel = 4'($urandom_range(0, 15)); i_dbus_we = 1'($urandom_range(0, 1));
        i_dbus_cyc = 1'b1;
      end
      if (!i_ibus_cyc && !i_dbus_cyc) begin
        i_wb_ack = 1'($urandom_range(0, 1));
        @(negedge i_clk);
        i_wb_ack = 1'b0;
        total++;
        if (o_wb_cyc !== 1'b0 || o_ibus_ack !== 1'b0 || o_dbus_ack !== 1'b0) begin
          bad++;
          $display("FAIL rand_idle: cyc=%b iack=%b dack=%b, want 0 0 0", o_wb_cyc, o_ibus_ack, o_dbus_ack);
        end
      end else begin
        d = ($urandom_range(0, 5) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
        run_txn("rand", d, $urandom, $urandom_range(0, 4) == 0);
      end
    end
    if (i_ibus_cyc || i_dbus_cyc) run_txn("rand_drain0", 0, $urandom, 1'b0);
    if (i_ibus_cyc || i_dbus_cyc) run_txn("rand_drain1", 0, $urandom, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_watchdog();
    test_stray_ack();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
